// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared types, encodings and condition evaluation for the multicycle control unit
package cu_pkg;

   // Main sequencer states
   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXECUTER,
      S_EXECUTEI,
      S_ALUWB,
      S_BRANCH
   } state_t;

   // ALU operation codes; EOR and MOV exist only when ALUControl is 3+ bits wide
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_ORR = 3'b011;
   localparam logic [2:0] ALU_EOR = 3'b100;
   localparam logic [2:0] ALU_MOV = 3'b101;

   // Data-processing cmd field encodings
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_EOR = 4'b0001;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;
   localparam logic [3:0] CMD_MOV = 4'b1101;

   // Instruction classes
   localparam logic [1:0] OP_DP    = 2'b00;
   localparam logic [1:0] OP_MEM   = 2'b01;
   localparam logic [1:0] OP_B     = 2'b10;
   localparam logic [1:0] OP_UNDEF = 2'b11;

   // Result and ALU B-operand mux encodings
   localparam logic [1:0] RES_ALUOUT     = 2'b00;
   localparam logic [1:0] RES_READ       = 2'b01;
   localparam logic [1:0] RES_ALU_DIRECT = 2'b10;
   localparam logic [1:0] SRCB_REG       = 2'b00;
   localparam logic [1:0] SRCB_IMM       = 2'b01;
   localparam logic [1:0] SRCB_FOUR      = 2'b10;

   // ARM condition evaluation against the stored NZCV flags
   function automatic logic condition_check(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v;
      {n, z, c, v} = nzcv;
      case (cond)
         4'b0000: condition_check = z;
         4'b0001: condition_check = ~z;
         4'b0010: condition_check = c;
         4'b0011: condition_check = ~c;
         4'b0100: condition_check = n;
         4'b0101: condition_check = ~n;
         4'b0110: condition_check = v;
         4'b0111: condition_check = ~v;
         4'b1000: condition_check = c & ~z;
         4'b1001: condition_check = ~c | z;
         4'b1010: condition_check = (n == v);
         4'b1011: condition_check = (n != v);
         4'b1100: condition_check = ~z & (n == v);
         4'b1101: condition_check = z | (n != v);
         default: condition_check = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/cu_alu_decoder.sv
// rtl/cu_alu_decoder.sv - data-processing cmd/S decode to ALU operation, flag-write mask and no-write
module cu_alu_decoder
   import cu_pkg::*;
#(
   parameter int ALU_CTRL_W = 2
) (
   input  logic [4:0]            funct,
   output logic [ALU_CTRL_W-1:0] alu_control,
   output logic [1:0]            flag_w,
   output logic                  no_write
);

   logic [3:0] cmd;
   logic       s;

   assign cmd = funct[4:1];
   assign s   = funct[0];

   // Unsupported commands (including EOR/MOV on a narrow ALU) become harmless no-ops
   always_comb begin
      alu_control = ALU_CTRL_W'(ALU_ADD);
      flag_w      = 2'b00;
      no_write    = 1'b0;
      case (cmd)
         CMD_ADD: begin
            alu_control = ALU_CTRL_W'(ALU_ADD);
            flag_w      = {s, s};
         end
         CMD_SUB: begin
            alu_control = ALU_CTRL_W'(ALU_SUB);
            flag_w      = {s, s};
         end
         CMD_AND: begin
            alu_control = ALU_CTRL_W'(ALU_AND);
            flag_w      = {s, 1'b0};
         end
         CMD_ORR: begin
            alu_control = ALU_CTRL_W'(ALU_ORR);
            flag_w      = {s, 1'b0};
         end
         CMD_CMP: begin
            alu_control = ALU_CTRL_W'(ALU_SUB);
            flag_w      = 2'b11;
            no_write    = 1'b1;
         end
         CMD_EOR: begin
            if (ALU_CTRL_W >= 3) begin
               alu_control = ALU_CTRL_W'(ALU_EOR);
               flag_w      = {s, 1'b0};
            end else begin
               no_write = 1'b1;
            end
         end
         CMD_MOV: begin
            if (ALU_CTRL_W >= 3) begin
               alu_control = ALU_CTRL_W'(ALU_MOV);
               flag_w      = {s, 1'b0};
            end else begin
               no_write = 1'b1;
            end
         end
         default: begin
            no_write = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle ARM control FSM with memory wait, timeout and flags
module multicycle_control_unit
   import cu_pkg::*;
#(
   parameter int ALU_CTRL_W  = 2,
   parameter int MEM_TIMEOUT = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            Cond,
   input  logic [1:0]            Op,
   input  logic [5:0]            Funct,
   input  logic [3:0]            Rd,
   input  logic [3:0]            ALUFlags,
   input  logic                  MemReady,
   output logic                  PCWrite,
   output logic                  AdrSrc,
   output logic                  MemRead,
   output logic                  MemWrite,
   output logic                  IRWrite,
   output logic                  RegWrite,
   output logic [1:0]            ResultSrc,
   output logic                  ALUSrcA,
   output logic [1:0]            ALUSrcB,
   output logic [1:0]            ImmSrc,
   output logic [1:0]            RegSrc,
   output logic [ALU_CTRL_W-1:0] ALUControl,
   output logic                  BusErr
);

   localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   state_t                state;
   state_t                next_state;
   logic [3:0]            nzcv;
   logic                  cond_ex_q;
   logic [CNT_W-1:0]      wait_cnt;
   logic [ALU_CTRL_W-1:0] dec_alu_control;
   logic [1:0]            flag_w;
   logic                  no_write;
   logic                  cond_ex;
   logic                  mem_wait;
   logic                  timeout;

   cu_alu_decoder #(
      .ALU_CTRL_W (ALU_CTRL_W)
   ) u_alu_decoder (
      .funct       (Funct[4:0]),
      .alu_control (dec_alu_control),
      .flag_w      (flag_w),
      .no_write    (no_write)
   );

   assign cond_ex  = condition_check(Cond, nzcv);
   assign mem_wait = ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR)) && !MemReady;
   assign timeout  = (MEM_TIMEOUT > 0) && mem_wait && (wait_cnt == CNT_LIMIT);

   assign ImmSrc = Op;
   assign RegSrc = {(Op == OP_MEM) && !Funct[0], (Op == OP_B)};

   // Next-state selection; a timeout abandons the access and returns to FETCH
   always_comb begin
      next_state = state;
      case (state)
         S_FETCH:    next_state = MemReady ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if (!cond_ex)                     next_state = S_FETCH;
            else if (Op == OP_MEM)            next_state = S_MEMADR;
            else if (Op == OP_DP && Funct[5]) next_state = S_EXECUTEI;
            else if (Op == OP_DP)             next_state = S_EXECUTER;
            else if (Op == OP_B)              next_state = S_BRANCH;
            else                              next_state = S_FETCH;
         end
         S_MEMADR:   next_state = Funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:    next_state = MemReady ? S_MEMWB : (timeout ? S_FETCH : S_MEMRD);
         S_MEMWR:    next_state = (MemReady || timeout) ? S_FETCH : S_MEMWR;
         S_EXECUTER,
         S_EXECUTEI: next_state = no_write ? S_FETCH : S_ALUWB;
         default:    next_state = S_FETCH;
      endcase
   end

   // State, condition latch, NZCV flags and memory wait counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_FETCH;
         nzcv      <= 4'b0000;
         cond_ex_q <= 1'b0;
         wait_cnt  <= '0;
      end else begin
         state <= next_state;
         if (state == S_DECODE) begin
            cond_ex_q <= cond_ex;
         end
         if (((state == S_EXECUTER) || (state == S_EXECUTEI)) && cond_ex_q) begin
            if (flag_w[1]) nzcv[3:2] <= ALUFlags[3:2];
            if (flag_w[0]) nzcv[1:0] <= ALUFlags[1:0];
         end
         // Cleared on timeout as well, since a FETCH timeout leaves the state unchanged
         if ((MEM_TIMEOUT == 0) || (next_state != state) || timeout) begin
            wait_cnt <= '0;
         end else if (mem_wait) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end
      end
   end

   // Moore output decode; strobes are forced low while reset is asserted
   always_comb begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = RES_ALU_DIRECT;
      ALUSrcA    = 1'b1;
      ALUSrcB    = SRCB_FOUR;
      ALUControl = ALU_CTRL_W'(ALU_ADD);
      BusErr     = timeout;
      case (state)
         S_FETCH: begin
            MemRead = 1'b1;
            IRWrite = MemReady;
            PCWrite = MemReady;
         end
         S_MEMADR: begin
            ALUSrcA    = 1'b0;
            ALUSrcB    = SRCB_IMM;
            ALUControl = Funct[3] ? ALU_CTRL_W'(ALU_ADD) : ALU_CTRL_W'(ALU_SUB);
         end
         S_MEMRD: begin
            AdrSrc  = 1'b1;
            MemRead = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc = RES_READ;
            RegWrite  = 1'b1;
            PCWrite   = (Rd == 4'd15);
         end
         S_MEMWR: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
         end
         S_EXECUTER: begin
            ALUSrcA    = 1'b0;
            ALUSrcB    = SRCB_REG;
            ALUControl = dec_alu_control;
         end
         S_EXECUTEI: begin
            ALUSrcA    = 1'b0;
            ALUSrcB    = SRCB_IMM;
            ALUControl = dec_alu_control;
         end
         S_ALUWB: begin
            ResultSrc = RES_ALUOUT;
            RegWrite  = 1'b1;
            PCWrite   = (Rd == 4'd15);
         end
         S_BRANCH: begin
            ALUSrcA   = 1'b0;
            ALUSrcB   = SRCB_IMM;
            ResultSrc = RES_ALU_DIRECT;
            PCWrite   = 1'b1;
         end
         default: begin
         end
      endcase
      if (!rst) begin
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         BusErr   = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] Cond;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic [3:0] ALUFlags;
   logic       MemReady;

   logic       a_PCWrite, a_AdrSrc, a_MemRead, a_MemWrite, a_IRWrite, a_RegWrite, a_ALUSrcA, a_BusErr;
   logic [1:0] a_ResultSrc, a_ALUSrcB, a_ImmSrc, a_RegSrc;
   logic [2:0] a_ALUControl;
   logic       b_PCWrite, b_AdrSrc, b_MemRead, b_MemWrite, b_IRWrite, b_RegWrite, b_ALUSrcA, b_BusErr;
   logic [1:0] b_ResultSrc, b_ALUSrcB, b_ImmSrc, b_RegSrc;
   logic [1:0] b_ALUControl;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   multicycle_control_unit #(.ALU_CTRL_W(3), .MEM_TIMEOUT(4)) dut_a (
      .clk(clk), .rst(rst), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
      .ALUFlags(ALUFlags), .MemReady(MemReady),
      .PCWrite(a_PCWrite), .AdrSrc(a_AdrSrc), .MemRead(a_MemRead), .MemWrite(a_MemWrite),
      .IRWrite(a_IRWrite), .RegWrite(a_RegWrite), .ResultSrc(a_ResultSrc), .ALUSrcA(a_ALUSrcA),
      .ALUSrcB(a_ALUSrcB), .ImmSrc(a_ImmSrc), .RegSrc(a_RegSrc), .ALUControl(a_ALUControl),
      .BusErr(a_BusErr)
   );

   multicycle_control_unit #(.ALU_CTRL_W(2), .MEM_TIMEOUT(0)) dut_b (
      .clk(clk), .rst(rst), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
      .ALUFlags(ALUFlags), .MemReady(MemReady),
      .PCWrite(b_PCWrite), .AdrSrc(b_AdrSrc), .MemRead(b_MemRead), .MemWrite(b_MemWrite),
      .IRWrite(b_IRWrite), .RegWrite(b_RegWrite), .ResultSrc(b_ResultSrc), .ALUSrcA(b_ALUSrcA),
      .ALUSrcB(b_ALUSrcB), .ImmSrc(b_ImmSrc), .RegSrc(b_RegSrc), .ALUControl(b_ALUControl),
      .BusErr(b_BusErr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f, input logic [3:0] r);
      Cond  = c;
      Op    = o;
      Funct = f;
      Rd    = r;
   endtask

   initial begin
      rst      = 1'b0;
      ALUFlags = 4'b0000;
      MemReady = 1'b0;
      set_instr(4'b1110, 2'b00, 6'b001000, 4'd1);
      #1;
      // Reset state: strobes low, FETCH mux values
      chk("rst_memread",   a_MemRead,    0);
      chk("rst_pcwrite",   a_PCWrite,    0);
      chk("rst_irwrite",   a_IRWrite,    0);
      chk("rst_alusrca",   a_ALUSrcA,    1);
      chk("rst_alusrcb",   a_ALUSrcB,    2'b10);
      chk("rst_resultsrc", a_ResultSrc,  2'b10);
      chk("rst_aluctl",    a_ALUControl, 0);
      tick();
      rst = 1'b1;

      // Test 1: STR reaching MEMWR, then reset mid-access
      set_instr(4'b1110, 2'b01, 6'b011000, 4'd5);
      MemReady = 1'b1;
      #1;
      chk("t1_fetch_irwrite", a_IRWrite, 1);
      tick();
      tick();
      #1;
      chk("t1_memadr_srcb", a_ALUSrcB, 2'b01);
      tick();
      MemReady = 1'b0;
      #1;
      chk("t1_memwr_write", a_MemWrite, 1);
      chk("t1_memwr_adr",   a_AdrSrc,   1);
      rst = 1'b0;
      #1;
      chk("t1_rst_memwrite", a_MemWrite, 0);
      chk("t1_rst_memwrite_b", b_MemWrite, 0);
      tick();
      rst = 1'b1;
      #1;
      chk("t1_post_fetch_read", a_MemRead, 1);
      chk("t1_post_fetch_ir",   a_IRWrite, 0);
      // BEQ right after reset: Z=0 so it must be squashed
      set_instr(4'b0000, 2'b10, 6'b100000, 4'd0);
      MemReady = 1'b1;
      #1;
      tick();
      #1;
      chk("t1_beq_decode_pcw", a_PCWrite, 0);
      tick();
      MemReady = 1'b0;
      #1;
      chk("t1_beq_squash_read", a_MemRead, 1);
      chk("t1_beq_squash_pcw",  a_PCWrite, 0);

      // Test 2: ADD R1, RegWrite only in the fourth cycle
      set_instr(4'b1110, 2'b00, 6'b001000, 4'd1);
      MemReady = 1'b1;
      #1;
      chk("t2_c1_regwrite", a_RegWrite, 0);
      chk("t2_c1_irwrite",  a_IRWrite,  1);
      tick();
      chk("t2_c2_regwrite", a_RegWrite, 0);
      chk("t2_c2_alusrca",  a_ALUSrcA,  1);
      tick();
      chk("t2_c3_regwrite", a_RegWrite, 0);
      chk("t2_c3_alusrca",  a_ALUSrcA,  0);
      chk("t2_c3_alusrcb",  a_ALUSrcB,  2'b00);
      chk("t2_c3_aluctl",   a_ALUControl, 3'b000);
      tick();
      chk("t2_c4_regwrite", a_RegWrite, 1);
      chk("t2_c4_result",   a_ResultSrc, 2'b00);
      chk("t2_c4_pcwrite",  a_PCWrite, 0);
      tick();
      chk("t2_c5_regwrite", a_RegWrite, 0);
      chk("t2_c5_memread",  a_MemRead, 1);

      // Test 3: SUBS R2 sets Z, BEQ taken, BNE squashed
      set_instr(4'b1110, 2'b00, 6'b000101, 4'd2);
      ALUFlags = 4'b0100;
      #1;
      tick();
      tick();
      chk("t3_subs_aluctl", a_ALUControl, 3'b001);
      tick();
      ALUFlags = 4'b0000;
      #1;
      chk("t3_subs_wb", a_RegWrite, 1);
      tick();
      set_instr(4'b0000, 2'b10, 6'b100000, 4'd0);
      #1;
      tick();
      tick();
      chk("t3_beq_pcwrite", a_PCWrite, 1);
      chk("t3_beq_srcb",    a_ALUSrcB, 2'b01);
      chk("t3_beq_result",  a_ResultSrc, 2'b10);
      tick();
      set_instr(4'b0001, 2'b10, 6'b100000, 4'd0);
      #1;
      tick();
      chk("t3_bne_decode_pcw", a_PCWrite, 0);
      tick();
      MemReady = 1'b0;
      #1;
      chk("t3_bne_fetch_read", a_MemRead, 1);
      chk("t3_bne_fetch_pcw",  a_PCWrite, 0);

      // Test 4: LDR R3 with three wait cycles in MEMRD
      set_instr(4'b1110, 2'b01, 6'b011001, 4'd3);
      MemReady = 1'b1;
      #1;
      tick();
      tick();
      chk("t4_memadr_add", a_ALUControl, 3'b000);
      chk("t4_immsrc",     a_ImmSrc, 2'b01);
      chk("t4_regsrc",     a_RegSrc, 2'b00);
      tick();
      MemReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t4_memrd_wait_read", a_MemRead, 1);
         chk("t4_memrd_wait_reg",  a_RegWrite, 0);
         tick();
      end
      MemReady = 1'b1;
      #1;
      chk("t4_memrd_last_read", a_MemRead, 1);
      chk("t4_memrd_last_adr",  a_AdrSrc, 1);
      chk("t4_limit_no_buserr", a_BusErr, 0);
      tick();
      chk("t4_memwb_reg",    a_RegWrite, 1);
      chk("t4_memwb_result", a_ResultSrc, 2'b01);
      chk("t4_memwb_pcw",    a_PCWrite, 0);
      chk("t4_memwb_reg_b",  b_RegWrite, 1);
      tick();
      // LDR PC with U=0: SUB address, PCWrite in MEMWB
      set_instr(4'b1110, 2'b01, 6'b010001, 4'd15);
      #1;
      tick();
      tick();
      chk("t4_pc_memadr_sub", a_ALUControl, 3'b001);
      tick();
      tick();
      chk("t4_pc_memwb_reg", a_RegWrite, 1);
      chk("t4_pc_memwb_pcw", a_PCWrite, 1);
      tick();

      // Test 5: STR with MemReady stuck low, timeout after four cycles
      set_instr(4'b1110, 2'b01, 6'b011000, 4'd6);
      #1;
      tick();
      tick();
      tick();
      MemReady = 1'b0;
      #1;
      chk("t5_regsrc", a_RegSrc, 2'b10);
      for (int i = 0; i < 3; i++) begin
         chk("t5_wait_write",  a_MemWrite, 1);
         chk("t5_wait_buserr", a_BusErr, 0);
         tick();
      end
      chk("t5_buserr",      a_BusErr, 1);
      chk("t5_buserr_reg",  a_RegWrite, 0);
      chk("t5_no_buserr_b", b_BusErr, 0);
      tick();
      chk("t5_after_fetch_read",  a_MemRead, 1);
      chk("t5_after_fetch_write", a_MemWrite, 0);
      chk("t5_after_buserr",      a_BusErr, 0);
      chk("t5_after_ir",          a_IRWrite, 0);
      chk("t5_b_still_writing",   b_MemWrite, 1);
      rst = 1'b0;
      tick();
      rst = 1'b1;

      // Test 6: EOR R4 with S=1 on a 3-bit ALU versus a 2-bit ALU
      set_instr(4'b1110, 2'b00, 6'b000011, 4'd4);
      MemReady = 1'b1;
      ALUFlags = 4'b0100;
      #1;
      tick();
      tick();
      chk("t6_eor_aluctl", a_ALUControl, 3'b100);
      tick();
      MemReady = 1'b0;
      ALUFlags = 4'b0000;
      #1;
      chk("t6_eor_wb_a",   a_RegWrite, 1);
      chk("t6_eor_nowb_b", b_RegWrite, 0);
      chk("t6_b_fetch",    b_MemRead, 1);
      tick();
      set_instr(4'b0000, 2'b10, 6'b100000, 4'd0);
      MemReady = 1'b1;
      #1;
      tick();
      tick();
      MemReady = 1'b0;
      #1;
      chk("t6_beq_taken_a",    a_PCWrite, 1);
      chk("t6_beq_squashed_b", b_PCWrite, 0);
      chk("t6_b_back_fetch",   b_MemRead, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
